// File: rtl/signal_sel_sequencer_pkg.sv
// Shared definitions for the signal select sequencer: FSM state encoding
// and the default select geometry of the four-source multiplexer.
package sig_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int NB_SEL_DEFAULT = 2;
  localparam int NUM_SOURCES    = 4;

endpackage

// File: rtl/signal_sel_sequencer_cycle_counter.sv
// Free-running up counter with synchronous clear and a terminal-count flag.
// Clear wins over enable so the owner can restart the count in the same
// cycle it would otherwise advance.
module cycle_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic at_terminal
);

  logic [WIDTH-1:0] count_reg;

  // Count register: clear has priority, otherwise advance when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  // Full-width compare so large terminal values are never truncated.
  assign at_terminal = (count_reg == TERMINAL);

endmodule

// File: rtl/signal_sel_sequencer.sv
// Select sequencer for the four-source signal generator/multiplexer.
// Auto mode scans the sources on a dwell timer (or on an i_next pulse);
// manual mode follows i_man_sel. Every select change is followed by a
// blanking window during which o_valid is low so the FIR capture discards
// the transient. All outputs are registered.
module signal_sel_sequencer
  import sig_seq_pkg::*;
#(
  parameter int                  NB_SEL       = NB_SEL_DEFAULT,
  parameter int                  NB_DWELL     = 24,
  parameter logic [NB_DWELL-1:0] DWELL_CYCLES = 24'd10_000_000,
  parameter int                  NB_BLANK     = 6,
  parameter logic [NB_BLANK-1:0] BLANK_CYCLES = 6'd32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_auto,
  input  logic [NB_SEL-1:0] i_man_sel,
  input  logic              i_next,
  output logic [NB_SEL-1:0] o_sel,
  output logic              o_valid,
  output logic              o_switch
);

  localparam logic [NB_DWELL-1:0] DWELL_LAST = DWELL_CYCLES - NB_DWELL'(1);
  localparam logic [NB_BLANK-1:0] BLANK_LAST = BLANK_CYCLES - NB_BLANK'(1);

  logic [1:0]        state_reg, state_next;
  logic [NB_SEL-1:0] sel_reg, sel_next;
  logic              valid_reg, valid_next;
  logic              switch_reg, switch_next;
  logic              auto_reg;

  logic in_run, in_blank;
  logic mode_toggle;
  logic dwell_done, blank_done;
  logic step_auto, step_man;
  logic dwell_clear, dwell_enable;
  logic blank_clear, blank_enable;

  assign in_run   = (state_reg == ST_RUN);
  assign in_blank = (state_reg == ST_BLANK);

  // A mode toggle in RUN costs one cycle: the dwell restarts and neither
  // mode may change the select until the new mode has settled.
  assign mode_toggle = (i_auto != auto_reg);

  // dwell_done and i_next are OR-ed into one step, so a coincidence
  // still advances the select by exactly one.
  assign step_auto = in_run &&  i_auto && !mode_toggle && (dwell_done || i_next);
  assign step_man  = in_run && !i_auto && !mode_toggle && (i_man_sel != sel_reg);

  assign dwell_enable = in_run && i_auto && !mode_toggle;
  assign dwell_clear  = !i_enable || !in_run || !i_auto || mode_toggle || step_auto;

  assign blank_enable = in_blank;
  assign blank_clear  = !i_enable || !in_blank || blank_done;

  cycle_counter #(
    .WIDTH    (NB_DWELL),
    .TERMINAL (DWELL_LAST)
  ) u_dwell (
    .clk         (i_clock),
    .rst_n       (i_reset),
    .clear       (dwell_clear),
    .enable      (dwell_enable),
    .at_terminal (dwell_done)
  );

  cycle_counter #(
    .WIDTH    (NB_BLANK),
    .TERMINAL (BLANK_LAST)
  ) u_blank (
    .clk         (i_clock),
    .rst_n       (i_reset),
    .clear       (blank_clear),
    .enable      (blank_enable),
    .at_terminal (blank_done)
  );

  // State register plus the previous-cycle mode used for toggle detection.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= ST_IDLE;
      auto_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      auto_reg  <= i_auto;
    end
  end

  // Next-state logic; dropping enable returns to IDLE from any state.
  always_comb begin
    state_next = state_reg;
    if (!i_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_BLANK;
        ST_BLANK: if (blank_done) state_next = ST_RUN;
        ST_RUN:   if (step_auto || step_man) state_next = ST_BLANK;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode: new select and switch pulse only on a RUN step, valid
  // only while the next state is RUN.
  always_comb begin
    sel_next    = sel_reg;
    switch_next = 1'b0;
    valid_next  = (state_next == ST_RUN);
    if (i_enable) begin
      if (step_auto) begin
        sel_next    = sel_reg + NB_SEL'(1);
        switch_next = 1'b1;
      end else if (step_man) begin
        sel_next    = i_man_sel;
        switch_next = 1'b1;
      end
    end
  end

  // Output registers so no input reaches an output combinationally.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sel_reg    <= '0;
      valid_reg  <= 1'b0;
      switch_reg <= 1'b0;
    end else begin
      sel_reg    <= sel_next;
      valid_reg  <= valid_next;
      switch_reg <= switch_next;
    end
  end

  assign o_sel    = sel_reg;
  assign o_valid  = valid_reg;
  assign o_switch = switch_reg;

endmodule

// File: tb/tb_signal_sel_sequencer.sv
// Bench for signal_sel_sequencer with DWELL_CYCLES=10 and BLANK_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, reflecting the edge just taken.
module tb_signal_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       auto_m;
  logic [1:0] man_sel;
  logic       nxt;
  logic [1:0] sel;
  logic       valid;
  logic       switch_p;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  signal_sel_sequencer #(
    .NB_SEL       (2),
    .NB_DWELL     (24),
    .DWELL_CYCLES (24'd10),
    .NB_BLANK     (6),
    .BLANK_CYCLES (6'd4)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_enable  (enable),
    .i_auto    (auto_m),
    .i_man_sel (man_sel),
    .i_next    (nxt),
    .o_sel     (sel),
    .o_valid   (valid),
    .o_switch  (switch_p)
  );

  typedef struct {
    logic       en;
    logic       au;
    logic [1:0] man;
    logic       nx;
    logic [1:0] esel;
    logic       evalid;
    logic       eswitch;
  } vec_t;

  vec_t vecs [19];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 1000 && cyc < target; g++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input int esel, input int ev, input int esw);
    chk({name, " sel"}, sel, esel);
    chk({name, " valid"}, valid, ev);
    chk({name, " switch"}, switch_p, esw);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, prev, s4, t0, u0, v0;
    bit found;

    // Manual-mode table: enable from IDLE, change 0->2 in RUN, change 2->3
    // mid-BLANK, i_next ignored in manual, enable dropped with a pending change.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0};

    rst_n = 1'b0; enable = 1'b0; auto_m = 1'b0; man_sel = 2'd0; nxt = 1'b0;
    tick(); tick();
    chk_out("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk_out("idle after reset", 0, 0, 0);

    // Auto scan: valid after 4 blank cycles, then steps every 14 cycles.
    enable = 1'b1; auto_m = 1'b1;
    tick();
    e0 = cyc;
    run_to(e0 + 3);
    chk("auto valid still low", valid, 0);
    tick();
    chk("auto valid rise", valid, 1);
    $display("auto: enabled at cycle %0d, valid at cycle %0d", e0, cyc);
    prev = e0;
    for (int k = 1; k <= 4; k++) begin
      found = 0;
      for (int t = 0; t < 40 && !found; t++) begin
        tick();
        if (switch_p) found = 1;
      end
      chk($sformatf("auto step%0d seen", k), found, 1);
      chk($sformatf("auto step%0d spacing", k), cyc - prev, 14);
      chk($sformatf("auto step%0d sel", k), sel, k % 4);
      $display("auto step %0d at cycle %0d sel=%0d", k, cyc, sel);
      prev = cyc;
      tick();
      chk($sformatf("auto step%0d pulse width", k), switch_p, 0);
    end
    s4 = prev;

    // i_next during BLANK is ignored.
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    chk_out("next in blank", 0, 0, 0);
    run_to(s4 + 4);
    chk_out("run after blank", 0, 1, 0);

    // i_next at dwell count 3 steps immediately.
    run_to(s4 + 7);
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    chk_out("next at dwell3", 1, 0, 1);
    $display("next at dwell 3: cycle %0d sel=%0d", cyc, sel);
    t0 = cyc;

    // i_next coinciding with dwell expiry gives exactly one step.
    run_to(t0 + 13);
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    chk_out("next at expiry", 2, 0, 1);
    tick();
    chk_out("expiry pulse end", 2, 0, 0);
    run_to(t0 + 18);
    chk_out("single step after expiry", 2, 1, 0);
    $display("coincident next/expiry: cycle %0d sel=%0d", cyc, sel);
    u0 = cyc;

    // Enable dropped at dwell count 5.
    run_to(u0 + 5);
    enable = 1'b0;
    tick();
    chk_out("disable in run", 2, 0, 0);
    tick(); tick();
    chk_out("disabled hold", 2, 0, 0);

    // Re-enable: 4-cycle blank, dwell restarts from 0.
    enable = 1'b1;
    tick();
    v0 = cyc;
    run_to(v0 + 3);
    chk("reenable valid low", valid, 0);
    tick();
    chk_out("reenable valid rise", 2, 1, 0);
    run_to(v0 + 13);
    chk_out("dwell restarted", 2, 1, 0);
    tick();
    chk_out("reenable step", 3, 0, 1);
    $display("re-enable at cycle %0d, step at cycle %0d sel=%0d", v0, cyc, sel);

    // Asynchronous reset mid-BLANK with sel=3.
    tick();
    chk_out("pre-reset blank", 3, 0, 0);
    #3;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk_out("async reset", 0, 0, 0);
    $display("async reset applied mid-cycle, sel=%0d valid=%0d", sel, valid);
    tick(); tick();
    rst_n = 1'b1;
    auto_m = 1'b0;
    tick(); tick(); tick();
    chk_out("idle after reset release", 0, 0, 0);

    // Manual table.
    for (int i = 0; i < 19; i++) begin
      enable  = vecs[i].en;
      auto_m  = vecs[i].au;
      man_sel = vecs[i].man;
      nxt     = vecs[i].nx;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].esel, vecs[i].evalid, vecs[i].eswitch);
      $display("vec %0d: en=%0d man=%0d -> sel=%0d valid=%0d switch=%0d",
               i, enable, man_sel, sel, valid, switch_p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
